// File: rtl/dcache_setassoc_wb.sv
// dcache_setassoc_wb: N-way set-associative, write-back, write-allocate data cache.
// Ports: clk_i/rst_ni clock and async active-low reset;
//   cpu_valid_i/we_i/addr_i/be_i/wdata_i -> cpu_rdata_o/cpu_ready_o/stall_o (MEM stage);
//   mem_req_o/we_o/addr_o/wdata_o <- mem_rdata_i/mem_ack_i (line-wide backing memory);
//   hit_cnt_o/miss_cnt_o saturating event counters.
module dcache_setassoc_wb #(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cpu_valid_i,
    input  logic                     cpu_we_i,
    input  logic [31:0]              cpu_addr_i,
    input  logic [3:0]               cpu_be_i,
    input  logic [31:0]              cpu_wdata_i,
    output logic [31:0]              cpu_rdata_o,
    output logic                     cpu_ready_o,
    output logic                     stall_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [31:0]              mem_addr_o,
    output logic [32*LINE_WORDS-1:0] mem_wdata_o,
    input  logic [32*LINE_WORDS-1:0] mem_rdata_i,
    input  logic                     mem_ack_i,
    output logic [31:0]              hit_cnt_o,
    output logic [31:0]              miss_cnt_o
);
    localparam int WO = $clog2(LINE_WORDS);
    localparam int OW = (WO > 0) ? WO : 1;
    localparam int IW = $clog2(SETS);
    localparam int TW = 30 - WO - IW;
    localparam int PW = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_e;
    state_e state_q, state_d;

    logic [31:0]     data_q  [WAYS][SETS][LINE_WORDS];
    logic [TW-1:0]   tag_q   [WAYS][SETS];
    logic [WAYS-1:0] valid_q [SETS];
    logic [WAYS-1:0] dirty_q [SETS];
    logic [PW-1:0]   ptr_q   [SETS];

    logic [IW-1:0] miss_idx_q;
    logic [TW-1:0] miss_tag_q;
    logic [PW-1:0] vic_q;
    logic          relook_q;
    logic [31:0]   hit_cnt_q;
    logic [31:0]   miss_cnt_q;

    logic [29:0]   wa;
    logic [OW-1:0] woff;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic          unused_addr;

    assign wa          = cpu_addr_i[31:2];
    assign unused_addr = ^cpu_addr_i[1:0];
    assign woff        = (LINE_WORDS > 1) ? OW'(wa) : '0;
    assign idx         = IW'(wa >> WO);
    assign tag         = TW'(wa >> (WO + IW));

    logic          hit;
    logic [PW-1:0] hit_way;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[w][idx] == tag) begin
                hit     = 1'b1;
                hit_way = PW'(w);
            end
        end
    end

    logic miss;
    logic fill_done;
    logic vic_dirty;

    assign miss        = (state_q == IDLE) && cpu_valid_i && !hit;
    assign fill_done   = (state_q == REFILL) && mem_ack_i;
    assign vic_dirty   = valid_q[idx][ptr_q[idx]] && dirty_q[idx][ptr_q[idx]];
    assign cpu_ready_o = (state_q == IDLE) && cpu_valid_i && hit;
    assign cpu_rdata_o = cpu_ready_o ? data_q[hit_way][idx][woff] : '0;
    // Forced low while reset is held so the pipeline is released at once.
    assign stall_o     = rst_ni && cpu_valid_i && !cpu_ready_o;
    assign hit_cnt_o   = hit_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;

    always_comb begin
        state_d     = state_q;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        unique case (state_q)
            IDLE: begin
                if (miss) state_d = vic_dirty ? WRITEBACK : REFILL;
            end
            WRITEBACK: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = {tag_q[vic_q][miss_idx_q], miss_idx_q, {(WO+2){1'b0}}};
                for (int k = 0; k < LINE_WORDS; k++)
                    mem_wdata_o[32*k +: 32] = data_q[vic_q][miss_idx_q][k];
                if (mem_ack_i) state_d = REFILL;
            end
            REFILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {miss_tag_q, miss_idx_q, {(WO+2){1'b0}}};
                if (mem_ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
            vic_q      <= '0;
            relook_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            state_q  <= state_d;
            relook_q <= 1'b0;
            if (miss) begin
                // Latch the line so the fill completes even if the CPU lets go.
                miss_idx_q <= idx;
                miss_tag_q <= tag;
                vic_q      <= ptr_q[idx];
                if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
            end
            // The re-lookup after a fill is not a first-look hit.
            if (cpu_ready_o && !relook_q && hit_cnt_q != '1)
                hit_cnt_q <= hit_cnt_q + 1'b1;
            if (cpu_ready_o && cpu_we_i)
                dirty_q[idx][hit_way] <= 1'b1;
            if (fill_done) begin
                valid_q[miss_idx_q][vic_q] <= 1'b1;
                dirty_q[miss_idx_q][vic_q] <= 1'b0;
                ptr_q[miss_idx_q] <= (WAYS > 1) ? vic_q + 1'b1 : '0;
                relook_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_done) begin
            tag_q[vic_q][miss_idx_q] <= miss_tag_q;
            for (int k = 0; k < LINE_WORDS; k++)
                data_q[vic_q][miss_idx_q][k] <= mem_rdata_i[32*k +: 32];
        end
        if (cpu_ready_o && cpu_we_i) begin
            for (int b = 0; b < 4; b++)
                if (cpu_be_i[b])
                    data_q[hit_way][idx][woff][8*b +: 8] <= cpu_wdata_i[8*b +: 8];
        end
    end
endmodule
